// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline/multi-cycle unit, the arbiter and the register file write port.
// Master drives the two writeback sources; slave (the arbiter) drives the write port and status.
interface regfile_wb_arbiter_if #(parameter int n = 32);
  logic         a_write;
  logic [4:0]   a_reg;
  logic [n-1:0] a_data;
  logic         b_valid;
  logic [4:0]   b_reg;
  logic [n-1:0] b_data;
  logic         b_ready;
  logic         rf_write;
  logic [4:0]   rf_write_reg;
  logic [n-1:0] rf_write_data;
  logic         stall_req;
  logic         busy;

  modport master (
    output a_write, a_reg, a_data, b_valid, b_reg, b_data,
    input  b_ready, rf_write, rf_write_reg, rf_write_data, stall_req, busy
  );

  modport slave (
    input  a_write, a_reg, a_data, b_valid, b_reg, b_data,
    output b_ready, rf_write, rf_write_reg, rf_write_data, stall_req, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges in-order writeback (A, always wins) and a buffered multi-cycle result (B) onto one write port.
// A lands 1 cycle after request, B at least 2 after accept; B starvation raises stall_req.
module regfile_wb_arbiter #(
  parameter int n        = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {EMPTY, HELD, STARVED} state_t;

  state_t       state;
  logic [4:0]   hold_reg;
  logic [n-1:0] hold_data;
  logic [WW-1:0] wait_cnt;
  logic         a_act;
  logic         b_acc;

  assign a_act       = bus.a_write && (bus.a_reg != 5'd0);
  assign bus.b_ready = (state == EMPTY) && !rst;
  assign b_acc       = bus.b_valid && bus.b_ready;
  assign bus.busy    = (state != EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= EMPTY;
      wait_cnt          <= '0;
      hold_reg          <= 5'd0;
      hold_data         <= '0;
      bus.rf_write      <= 1'b0;
      bus.rf_write_reg  <= 5'd0;
      bus.rf_write_data <= '0;
      bus.stall_req     <= 1'b0;
    end else begin
      bus.rf_write <= 1'b0;
      if (a_act) begin
        bus.rf_write      <= 1'b1;
        bus.rf_write_reg  <= bus.a_reg;
        bus.rf_write_data <= bus.a_data;
      end
      case (state)
        EMPTY: begin
          // x0 results complete the handshake but are dropped here
          if (b_acc && (bus.b_reg != 5'd0)) begin
            hold_reg  <= bus.b_reg;
            hold_data <= bus.b_data;
            wait_cnt  <= '0;
            state     <= HELD;
          end
        end
        HELD: begin
          if (!a_act) begin
            bus.rf_write      <= 1'b1;
            bus.rf_write_reg  <= hold_reg;
            bus.rf_write_data <= hold_data;
            state             <= EMPTY;
          end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
            wait_cnt      <= wait_cnt + 1'b1;
            bus.stall_req <= 1'b1;
            state         <= STARVED;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STARVED: begin
          if (!a_act) begin
            bus.rf_write      <= 1'b1;
            bus.rf_write_reg  <= hold_reg;
            bus.rf_write_data <= hold_data;
            bus.stall_req     <= 1'b0;
            wait_cnt          <= '0;
            state             <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus hand-written starvation/reset sequences,
// with every register-file write checked against a queue of expected writes.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.n(32)) bus ();

  regfile_wb_arbiter #(.n(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        aw;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        exp_wr;
    logic        exp_busy;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_write = 1'b0;
    bus.a_reg   = 5'd0;
    bus.a_data  = 32'd0;
    bus.b_valid = 1'b0;
    bus.b_reg   = 5'd0;
    bus.b_data  = 32'd0;
  endtask

  // Write monitor: every rf_write must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.rf_write === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %h, no write expected at %0t",
                 bus.rf_write_reg, bus.rf_write_data, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_reg", 32'(bus.rf_write_reg), 32'(e.r));
        chk("write_data", bus.rf_write_data, e.d);
      end
    end
  end

  initial begin
    int na;
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  32'h0BAD0BAD, 1'b0, 5'd0,  32'd0,        1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd7,  32'h00001234, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'h55555555, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, 5'd11, 32'hB1B1B1B1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 5'd0,  32'hCCCCCCCC, 1'b1, 5'd12, 32'hC2C2C2C2, 1'b0, 1'b1};

    // Reset with both sources requesting
    rst         = 1'b1;
    bus.a_write = 1'b1;
    bus.a_reg   = 5'd5;
    bus.a_data  = 32'h11111111;
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd6;
    bus.b_data  = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rf_write", 32'(bus.rf_write), 32'd0);
      chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
      chk("rst_stall", 32'(bus.stall_req), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
    end
    chk("rst_write_reg", 32'(bus.rf_write_reg), 32'd0);
    chk("rst_write_data", bus.rf_write_data, 32'd0);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("post_rst_b_ready", 32'(bus.b_ready), 32'd1);
    tick();

    // Single-cycle stimulus table, each from EMPTY followed by idle cycles
    for (int i = 0; i < 6; i++) begin
      bus.a_write = vecs[i].aw;
      bus.a_reg   = vecs[i].ar;
      bus.a_data  = vecs[i].ad;
      bus.b_valid = vecs[i].bv;
      bus.b_reg   = vecs[i].br;
      bus.b_data  = vecs[i].bd;
      if (vecs[i].aw && vecs[i].ar != 5'd0) sb.push_back('{vecs[i].ar, vecs[i].ad});
      if (vecs[i].bv && vecs[i].br != 5'd0) sb.push_back('{vecs[i].br, vecs[i].bd});
      tick();
      idle_inputs();
      chk("vec_rf_write_t1", 32'(bus.rf_write), 32'(vecs[i].exp_wr));
      chk("vec_busy_t1", 32'(bus.busy), 32'(vecs[i].exp_busy));
      chk("vec_b_ready_t1", 32'(bus.b_ready), 32'(!vecs[i].exp_busy));
      chk("vec_stall_t1", 32'(bus.stall_req), 32'd0);
      tick();
      tick();
      chk("vec_b_ready_t3", 32'(bus.b_ready), 32'd1);
      chk("vec_busy_t3", 32'(bus.busy), 32'd0);
    end

    // Starvation: hold B reg 9 while A writes every cycle
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd9;
    bus.b_data  = 32'h99999999;
    tick();
    idle_inputs();
    chk("starve_busy", 32'(bus.busy), 32'd1);
    na = 0;
    for (int i = 0; i < 10; i++) begin
      bus.a_write = 1'b1;
      bus.a_reg   = 5'(20 + i);
      bus.a_data  = 32'hA5000000 + 32'(i);
      sb.push_back('{5'(20 + i), 32'hA5000000 + 32'(i)});
      na++;
      tick();
      if (bus.stall_req) break;
    end
    chk("starve_a_writes_before_stall", 32'(na), 32'd4);
    bus.a_reg  = 5'd30;
    bus.a_data = 32'hA5A5A5A5;
    sb.push_back('{5'd30, 32'hA5A5A5A5});
    tick();
    chk("starve_stall_held", 32'(bus.stall_req), 32'd1);
    chk("starve_busy_held", 32'(bus.busy), 32'd1);
    chk("starve_b_ready", 32'(bus.b_ready), 32'd0);
    idle_inputs();
    sb.push_back('{5'd9, 32'h99999999});
    tick();
    chk("starve_grant", 32'(bus.rf_write), 32'd1);
    chk("starve_stall_drop", 32'(bus.stall_req), 32'd0);
    chk("starve_busy_drop", 32'(bus.busy), 32'd0);
    chk("starve_b_ready_back", 32'(bus.b_ready), 32'd1);
    tick();

    // Reset while a B result is held: it must never be written
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd3;
    bus.b_data  = 32'h33333333;
    tick();
    idle_inputs();
    chk("rstheld_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstheld_busy_after", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("rstheld_idle_busy", 32'(bus.busy), 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
